// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-controller-side signals of mem_port_arbiter, bundled for port passing.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int unsigned REQ_CNT = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  logic [2*REQ_CNT-1:0]      req_rw_flag;
  logic [ADDR_W*REQ_CNT-1:0] req_addr;
  logic [DATA_W*REQ_CNT-1:0] req_write_data;
  logic [4*REQ_CNT-1:0]      req_write_mask;
  logic [DATA_W*REQ_CNT-1:0] req_read_data;
  logic [REQ_CNT-1:0]        req_busy;
  logic [REQ_CNT-1:0]        req_done;

  logic [1:0]                MEM_rw_flag;
  logic [ADDR_W-1:0]         MEM_addr;
  logic [DATA_W-1:0]         MEM_write_data;
  logic [3:0]                MEM_write_mask;
  logic [DATA_W-1:0]         MEM_read_data;
  logic                      MEM_busy;
  logic                      MEM_done;

  modport slave (
    input  req_rw_flag, req_addr, req_write_data, req_write_mask,
    input  MEM_read_data, MEM_busy, MEM_done,
    output req_read_data, req_busy, req_done,
    output MEM_rw_flag, MEM_addr, MEM_write_data, MEM_write_mask
  );

  modport master (
    output req_rw_flag, req_addr, req_write_data, req_write_mask,
    output MEM_read_data, MEM_busy, MEM_done,
    input  req_read_data, req_busy, req_done,
    input  MEM_rw_flag, MEM_addr, MEM_write_data, MEM_write_mask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory-controller port among REQ_CNT requesters, one transaction in flight.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module mem_port_arbiter #(
  parameter int unsigned REQ_CNT = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input logic               CLK,
  input logic               RST_N,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StDone} state_e;

  state_e                    state_q;
  logic [IdxW-1:0]           gnt_q;
  logic [1:0]                rw_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [DATA_W-1:0]         wdata_q;
  logic [3:0]                mask_q;
  logic [REQ_CNT-1:0]        busy_q;
  logic [REQ_CNT-1:0]        done_q;
  logic [DATA_W*REQ_CNT-1:0] rdata_q;

  logic [REQ_CNT-1:0]        valid;
  logic [IdxW-1:0]           win;
  logic [1:0]                sel_rw;
  logic [ADDR_W-1:0]         sel_addr;
  logic [DATA_W-1:0]         sel_wdata;
  logic [3:0]                sel_mask;

  // Flag 11 is illegal and never counts as a request.
  always_comb begin
    valid = '0;
    for (int i = 0; i < int'(REQ_CNT); i++) begin
      valid[i] = (bus.req_rw_flag[2*i +: 2] == 2'b01) || (bus.req_rw_flag[2*i +: 2] == 2'b10);
    end
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = int'(REQ_CNT) - 1; i >= 0; i--) begin
      if (valid[i]) win = IdxW'(i);
    end
  end
`else
  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] cand;

  // Walk offsets from farthest to nearest so the first valid after rr_ptr wins.
  always_comb begin
    win  = '0;
    cand = '0;
    for (int i = int'(REQ_CNT); i >= 1; i--) begin
      cand = IdxW'((int'(rr_ptr_q) + i) % int'(REQ_CNT));
      if (valid[cand]) win = cand;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr_q <= IdxW'(REQ_CNT - 1);
    end else if (state_q == StGrant && bus.MEM_done) begin
      rr_ptr_q <= gnt_q;
    end
  end
`endif

  always_comb begin
    sel_rw    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    for (int i = 0; i < int'(REQ_CNT); i++) begin
      if (win == IdxW'(i)) begin
        sel_rw    = bus.req_rw_flag[2*i +: 2];
        sel_addr  = bus.req_addr[ADDR_W*i +: ADDR_W];
        sel_wdata = bus.req_write_data[DATA_W*i +: DATA_W];
        sel_mask  = bus.req_write_mask[4*i +: 4];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      rw_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= '0;
          if ((|valid) && !bus.MEM_busy) begin
            gnt_q   <= win;
            rw_q    <= sel_rw;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            mask_q  <= sel_mask;
            busy_q  <= REQ_CNT'(1) << win;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (bus.MEM_done) begin
            for (int i = 0; i < int'(REQ_CNT); i++) begin
              if (gnt_q == IdxW'(i) && rw_q == 2'b01) begin
                rdata_q[DATA_W*i +: DATA_W] <= bus.MEM_read_data;
              end
            end
            rw_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            busy_q  <= '0;
            done_q  <= REQ_CNT'(1) << gnt_q;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.MEM_rw_flag    = rw_q;
  assign bus.MEM_addr       = addr_q;
  assign bus.MEM_write_data = wdata_q;
  assign bus.MEM_write_mask = mask_q;
  assign bus.req_busy       = busy_q;
  assign bus.req_done       = done_q;
  assign bus.req_read_data  = rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory_controller port (PORT_COUNT=1) between REQ_CNT requesters inside cpu_core, e.g. port 0 = instruction fetch, port 1 = load/store unit.
- Round-robin grant; one transaction in flight at a time.
- Requester-side signals mirror the MEM_* port protocol so requesters stay unchanged when moved behind the arbiter.

Parameters:
REQ_CNT, 2, number of requesters (2..4)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
req_rw_flag  in  2*REQ_CNT  per requester: 00 idle, 01 read, 10 write, 11 illegal (treated as idle)
req_addr  in  ADDR_W*REQ_CNT  per-requester address
req_write_data  in  DATA_W*REQ_CNT  per-requester write data
req_write_mask  in  4*REQ_CNT  per-requester byte mask
req_read_data  out  DATA_W*REQ_CNT  per-requester read data, held until that requester's next done
req_busy  out  REQ_CNT  requester has a granted transaction in progress
req_done  out  REQ_CNT  one-cycle completion pulse
MEM_rw_flag  out  2  to memory_controller
MEM_addr  out  ADDR_W  to memory_controller
MEM_write_data  out  DATA_W  to memory_controller
MEM_write_mask  out  4  to memory_controller
MEM_read_data  in  DATA_W  from memory_controller
MEM_busy  in  1  controller busy
MEM_done  in  1  controller one-cycle completion pulse

Behaviour:
- Reset (RST_N low, async): state IDLE; all outputs 0; rr_ptr = REQ_CNT-1, so requester 0 wins the first arbitration.
- FSM states:
  - IDLE: if any request is valid and MEM_busy==0, pick the winner, latch its index and rw_flag/addr/data/mask into registers, go to GRANT. Otherwise stay.
  - GRANT: MEM_* driven from the latched registers; MEM_rw_flag nonzero; req_busy[g]=1. Stay until MEM_done==1. On MEM_done:
    - capture MEM_read_data into req_read_data[g] (reads only; writes leave it unchanged);
    - set rr_ptr=g;
    - go to DONE.
  - DONE: req_done[g]=1 for exactly this cycle; MEM_rw_flag=00; req_busy[g]=0. Always go to IDLE.
- Arbitration: round-robin search starting at rr_ptr+1 mod REQ_CNT; the first valid requester wins.
- Latency: request seen in IDLE at cycle 0 → MEM_rw_flag asserted at cycle 1. MEM_done at cycle k → req_done at k+1, IDLE at k+2. The earliest next grant is at k+3, giving at least 2 cycles of MEM_rw_flag=00 between transactions.
- Requester rule: hold rw_flag/addr/data/mask stable until req_done. The arbiter latches them at grant, so later changes do not affect the in-flight transaction.
  - Withdrawal before grant: the request is simply never seen.
  - Deassertion after grant: the transaction still completes and req_done still pulses.
  - The requester must drop or change rw_flag in the req_done cycle. A flag still nonzero in IDLE is treated as a new request.
- MEM_busy==1 in IDLE: no grant; requests wait, with no starvation penalty.
- MEM_done in IDLE or DONE: ignored.
- Reset mid-GRANT: outputs clear immediately; no req_done for the aborted transaction.
- Illegal flag 11: never granted.

Optional Feature:
MEM_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest index always wins, rr_ptr is unused and optimised away.
- Undefined: round-robin as above.
- All timing is identical in both modes.

Test Plan:
- Reset, then requester 0 reads addr 0x100; controller returns 0xDEADBEEF with MEM_done 3 cycles after grant:
  - MEM_rw_flag=01 and MEM_addr=0x100 at cycle 1;
  - req_done[0] one cycle after MEM_done;
  - req_read_data[0]=0xDEADBEEF.
- Requesters 0 and 1 request in the same cycle after reset (rr_ptr=1):
  - requester 0 is served first, then requester 1;
  - with both held continuously, grants alternate 0,1,0,1.
  - Under MEM_ARB_FIXED_PRIO_EN with both held continuously: grants are 0,0,0…; requester 1 is served only after requester 0 drops its request.
- Requester 1 writes 0x12345678 with mask 4'b0011 to 0x200:
  - MEM_rw_flag=10 with exact data and mask;
  - req_read_data[1] unchanged;
  - req_done[1] is a single-cycle pulse.
- MEM_busy=1 for 5 cycles with requester 0 pending: MEM_rw_flag stays 00 until the cycle after MEM_busy falls.
- RST_N low during GRANT:
  - all outputs 0 asynchronously;
  - no req_done;
  - after release, requester 0 re-arbitrates from IDLE.
- Requester 0 changes req_addr to 0x300 mid-transaction: MEM_addr holds the original 0x100 until done.
